// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver:
//   - glyph patterns in active-high {a,b,c,d,e,f,g} form, a = bit 6
//   - glyph-set selection encoding (BCD+symbols vs. full hex)
//   - decode(): maps a 4-bit digit code to its glyph for a given glyph set
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Glyph set selection
    localparam logic MODE_BCD = 1'b0;
    localparam logic MODE_HEX = 1'b1;

    localparam seg_t GLYPH_BLANK = 7'b0000000;

    // Decimal digits, shared by both glyph sets
    localparam seg_t GLYPH_0 = 7'b1111110;
    localparam seg_t GLYPH_1 = 7'b0110000;
    localparam seg_t GLYPH_2 = 7'b1101101;
    localparam seg_t GLYPH_3 = 7'b1111001;
    localparam seg_t GLYPH_4 = 7'b0110011;
    localparam seg_t GLYPH_5 = 7'b1011011;
    localparam seg_t GLYPH_6 = 7'b1011111;
    localparam seg_t GLYPH_7 = 7'b1110000;
    localparam seg_t GLYPH_8 = 7'b1111111;
    localparam seg_t GLYPH_9 = 7'b1111011;

    // Status symbols used by the BCD glyph set
    localparam seg_t GLYPH_SYM_P  = 7'b1100111;
    localparam seg_t GLYPH_SYM_A  = 7'b1110111;
    localparam seg_t GLYPH_DASH   = 7'b0000001;

    // Hex letters
    localparam seg_t GLYPH_HEX_A = 7'b1110111;
    localparam seg_t GLYPH_HEX_B = 7'b0011111;
    localparam seg_t GLYPH_HEX_C = 7'b1001110;
    localparam seg_t GLYPH_HEX_D = 7'b0111101;
    localparam seg_t GLYPH_HEX_E = 7'b1001111;
    localparam seg_t GLYPH_HEX_F = 7'b1000111;

    function automatic seg_t decode(input logic [3:0] code, input logic hex_mode);
        seg_t g;
        case (code)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            4'd10:   g = (hex_mode == MODE_HEX) ? GLYPH_HEX_A : GLYPH_BLANK;
            4'd11:   g = (hex_mode == MODE_HEX) ? GLYPH_HEX_B : GLYPH_BLANK;
            4'd12:   g = (hex_mode == MODE_HEX) ? GLYPH_HEX_C : GLYPH_SYM_P;
            4'd13:   g = (hex_mode == MODE_HEX) ? GLYPH_HEX_D : GLYPH_SYM_A;
            4'd14:   g = (hex_mode == MODE_HEX) ? GLYPH_HEX_E : GLYPH_BLANK;
            default: g = (hex_mode == MODE_HEX) ? GLYPH_HEX_F : GLYPH_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Frame-load handshake between the producer of digit codes and the driver.
//   load_valid : producer offers a frame
//   load_data  : 4 bits per digit, digit 0 in bits [3:0] (rightmost digit)
//   load_ready : driver can accept a frame
// master = frame producer, slave = seg7_scan_driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic                      load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg7_glyph_rom.sv
// -----------------------------------------------------------------------------
// seg7_glyph_rom
// Combinational glyph lookup for one digit, active-high segment form.
//   code     : 4-bit digit code
//   hex_mode : glyph set select (MODE_BCD / MODE_HEX)
//   blank    : forces all segments off
//   seg      : {a,b,c,d,e,f,g}, a = bit 6
// -----------------------------------------------------------------------------
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? GLYPH_BLANK : decode(code, hex_mode);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for a NUM_DIGITS-wide 7-segment display. A frame of
// digit codes is loaded into a shadow register over a valid/ready handshake
// and transferred to the display register only at a frame boundary (or at
// once while scanning is disabled), so a frame is never shown half-updated.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : 1 = scan, 0 = hold scan position and blank the display
//   lz_suppress : 1 = blank leading zero digits (digit 0 always shown)
//   load_if     : frame handshake (slave side)
//   seg         : segments {a,b,c,d,e,f,g}, a = bit 6, registered
//   an          : digit select, one-hot when active, registered
//   digit_idx   : index of the digit currently being scanned
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W         = $clog2(NUM_DIGITS),
    localparam int PS_W          = $clog2(SCAN_DIV)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   lz_suppress,
    seg7_scan_driver_if.slave      load_if,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [IDX_W-1:0]       digit_idx
);

    localparam int                  DW       = 4 * NUM_DIGITS;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic                HEX_SEL  = (HEX_MODE != 0) ? MODE_HEX : MODE_BCD;
    // Inactive levels after polarity is applied
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ?
                                                {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PS_W-1:0]       prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [DW-1:0]         disp_q,      disp_d;
    logic [DW-1:0]         shadow_q,    shadow_d;
    logic                  pending_q,   pending_d;
    logic [NUM_DIGITS-1:0] an_q,        an_d;
    logic [6:0]            seg_q,       seg_d;

    logic                  ps_terminal;
    logic                  frame_boundary;

    logic [3:0]            digit_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    logic [6:0]            glyph;

    assign ps_terminal    = (prescaler_q == PS_LAST);
    assign frame_boundary = enable && ps_terminal && (digit_idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_comb begin
        prescaler_d = prescaler_q;
        digit_idx_d = digit_idx_q;
        if (enable) begin
            if (ps_terminal) begin
                prescaler_d = '0;
                digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
            end else begin
                prescaler_d = prescaler_q + PS_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame handshake. ready is simply "no frame waiting in the shadow",
    // so a second frame can never overwrite one that has not been shown.
    // ------------------------------------------------------------------
    assign load_if.load_ready = ~pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (pending_q) begin
            // With the scan stopped there is no boundary to wait for.
            if (frame_boundary || !enable) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load_if.load_valid) begin
            shadow_d  = load_if.load_data;
            pending_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-digit view of the display register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_code[gi] = disp_q[4*gi +: 4];
        // Dead time at prescaler 0 keeps the previous digit's segments from
        // ghosting onto the newly selected anode.
        assign an_sel[gi] = enable && (prescaler_q != '0) && (digit_idx_q == IDX_W'(gi));
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (digit_code[i] == 4'd0);
            lz_mask[i] = zero_run && (i != 0);
        end
    end

    assign cur_code  = digit_code[digit_idx_q];
    assign cur_blank = !enable || (lz_suppress && lz_mask[digit_idx_q]);

    seg7_glyph_rom u_glyph_rom (
        .code     (cur_code),
        .hex_mode (HEX_SEL),
        .blank    (cur_blank),
        .seg      (glyph)
    );

    // ------------------------------------------------------------------
    // Output registers: an and seg share one register stage so they always
    // switch on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        an_d  = (AN_ACTIVE_LOW != 0)  ? ~an_sel : an_sel;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~glyph  : glyph;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            disp_q      <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            disp_q      <= disp_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS = 4, SCAN_DIV = 4.
// Two instances share clock and reset: a BCD glyph set instance (u_bcd) and a
// hex glyph set instance (u_hex). Expected digit glyphs are queued when a
// frame is offered and popped as the scan reaches each digit.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic en_b, lz_b, en_h, lz_h;
    logic [6:0] seg_b, seg_h;
    logic [3:0] an_b, an_h;
    logic [1:0] idx_b, idx_h;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_b ();
    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus_h ();

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) u_bcd (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .lz_suppress(lz_b),
        .load_if(bus_b), .seg(seg_b), .an(an_b), .digit_idx(idx_b)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) u_hex (
        .clk(clk), .rst_n(rst_n), .enable(en_h), .lz_suppress(lz_h),
        .load_if(bus_h), .seg(seg_h), .an(an_h), .digit_idx(idx_h)
    );

    // Observed signals of whichever instance is under test
    bit         use_hex = 1'b0;
    logic [6:0] seg_m;
    logic [3:0] an_m;
    logic [1:0] idx_m;
    logic       ready_m;
    always_comb begin
        seg_m   = use_hex ? seg_h : seg_b;
        an_m    = use_hex ? an_h  : an_b;
        idx_m   = use_hex ? idx_h : idx_b;
        ready_m = use_hex ? bus_h.load_ready : bus_b.load_ready;
    end

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the glyphs of one frame in scan order (digit 0 first)
    task automatic push_frame(input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3);
        logic [6:0] g [4];
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            e.an     = 4'hF;
            e.an[d]  = 1'b0;
            e.seg    = g[d];
            e.idx    = 2'(d);
            sb.push_back(e);
        end
    endtask

    // Entered just after the edge that starts digit 0 (adv = 0) or one cycle
    // later (adv = 1). Leaves just after the edge that starts the next frame.
    task automatic scan_frame(input string tag, input bit adv);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            if (!(adv && d == 0)) @(negedge clk);
            check($sformatf("%s_d%0d_dead_an", tag, d), 32'(an_m), 32'hF);
            @(negedge clk);
            if (sb.size() == 0) begin
                $display("FAIL %s_d%0d scoreboard empty", tag, d);
                $fatal(1, "scoreboard underflow");
            end
            e = sb.pop_front();
            check($sformatf("%s_d%0d_an", tag, d),  32'(an_m),  32'(e.an));
            check($sformatf("%s_d%0d_seg", tag, d), 32'(seg_m), 32'(e.seg));
            check($sformatf("%s_d%0d_idx", tag, d), 32'(idx_m), 32'(e.idx));
            @(negedge clk);
            @(negedge clk);
        end
        $display("frame %s scanned", tag);
    endtask

    // Offer a frame for one cycle; it must be taken at the next edge.
    task automatic load_frame(input logic [15:0] data);
        if (use_hex) begin
            bus_h.load_valid = 1'b1; bus_h.load_data = data;
        end else begin
            bus_b.load_valid = 1'b1; bus_b.load_data = data;
        end
        @(negedge clk);
        bus_h.load_valid = 1'b0;
        bus_b.load_valid = 1'b0;
        check($sformatf("load_%h_ready_low", data), 32'(ready_m), 32'h0);
        $display("load %h offered", data);
    endtask

    // Wait (bounded) for digit_idx to wrap 3 -> 0; report ready seen one
    // cycle before the wrap was observed.
    task automatic wait_boundary(output logic prev_ready);
        logic [1:0] prev_idx;
        bit         found;
        found      = 1'b0;
        prev_idx   = idx_m;
        prev_ready = ready_m;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prev_idx == 2'd3 && idx_m == 2'd0) found = 1'b1;
            else begin
                prev_idx   = idx_m;
                prev_ready = ready_m;
            end
        end
        check("boundary_seen", 32'(found), 32'h1);
    endtask

    localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001, G4 = 7'b0110011, G5 = 7'b1011011;
    localparam logic [6:0] G9 = 7'b1111011, GP = 7'b1100111, GD = 7'b0000001;
    localparam logic [6:0] GB = 7'b0000000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pr;
        rst_n = 1'b0;
        en_b = 1'b1; lz_b = 1'b0; en_h = 1'b1; lz_h = 1'b0;
        bus_b.load_valid = 1'b0; bus_b.load_data = '0;
        bus_h.load_valid = 1'b0; bus_h.load_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an",    32'(an_m),    32'hF);
        check("rst_seg",   32'(seg_m),   32'h0);
        check("rst_idx",   32'(idx_m),   32'h0);
        check("rst_ready", 32'(ready_m), 32'h1);
        rst_n = 1'b1;

        // Free scan of the all-zero frame, two frames to see the wrap
        push_frame(G0, G0, G0, G0);
        scan_frame("zero_a", 1'b0);
        push_frame(G0, G0, G0, G0);
        scan_frame("zero_b", 1'b0);

        // Mid-frame load of 12CF while digit 1 is scanned
        repeat (6) @(negedge clk);
        bus_b.load_valid = 1'b1; bus_b.load_data = 16'h12CF;
        @(negedge clk);
        check("12cf_ready_low", 32'(ready_m), 32'h0);
        // Offer 9999 while 12CF is still pending; it must be held off
        bus_b.load_data = 16'h9999;
        repeat (3) @(negedge clk);
        check("pre_boundary_an",  32'(an_m),    32'hB);
        check("pre_boundary_seg", 32'(seg_m),   32'(G0));
        check("9999_blocked",     32'(ready_m), 32'h0);
        wait_boundary(pr);
        check("ready_before_boundary", 32'(pr),      32'h0);
        check("ready_after_boundary",  32'(ready_m), 32'h1);
        @(negedge clk);
        check("9999_accepted", 32'(ready_m), 32'h0);
        bus_b.load_valid = 1'b0;
        push_frame(GD, GP, G2, G1);
        scan_frame("f12cf", 1'b1);

        // 9999 shows next; leading-zero suppression on for the following frames
        lz_b = 1'b1;
        push_frame(G9, G9, G9, G9);
        load_frame(16'h0050);
        scan_frame("f9999", 1'b1);
        push_frame(G0, G5, GB, GB);
        load_frame(16'h0000);
        scan_frame("f0050", 1'b1);
        push_frame(G0, GB, GB, GB);
        scan_frame("f0000", 1'b0);

        // Scan disabled: blank outputs, held position, immediate frame copy
        en_b = 1'b0;
        @(negedge clk);
        check("dis_an",  32'(an_m),  32'hF);
        check("dis_seg", 32'(seg_m), 32'h0);
        check("dis_idx", 32'(idx_m), 32'h0);
        load_frame(16'h1234);
        @(negedge clk);
        check("dis_copy_ready", 32'(ready_m), 32'h1);
        check("dis_idx_held",   32'(idx_m),   32'h0);
        en_b = 1'b1;
        push_frame(G4, G3, G2, G1);
        scan_frame("f1234", 1'b0);

        // Asynchronous reset with a frame pending
        lz_b = 1'b0;
        load_frame(16'h5678);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_an",    32'(an_m),    32'hF);
        check("arst_seg",   32'(seg_m),   32'h0);
        check("arst_ready", 32'(ready_m), 32'h1);
        check("arst_idx",   32'(idx_m),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(G0, G0, G0, G0);
        scan_frame("post_rst_a", 1'b0);
        push_frame(G0, G0, G0, G0);
        scan_frame("post_rst_b", 1'b0);

        // Hex glyph set instance
        use_hex = 1'b1;
        push_frame(G0, G0, G0, G0);
        load_frame(16'hABCD);
        scan_frame("hex_pre", 1'b1);
        push_frame(7'b0111101, 7'b1001110, 7'b0011111, 7'b1110111);
        scan_frame("hex_abcd", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a NUM_DIGITS-wide common-anode/cathode 7-segment display.
- Holds a frame of 4-bit digit codes loaded over a valid/ready handshake and scans one digit at a time at a programmable rate.
- Decodes each digit in BCD-with-symbols or full-hex mode, with optional leading-zero suppression.
- Applies new frames only at frame boundaries so the display never tears; sits between the datapath/status logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 1000, clk cycles each digit is selected (>= 2).
- HEX_MODE, 0, 0 = BCD+symbol glyph set, 1 = hex glyph set.
- SEG_ACTIVE_LOW, 0, 1 inverts seg outputs.
- AN_ACTIVE_LOW, 1, 1 makes an outputs active-low.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, scan enable; 0 holds the scan and blanks the display.
- lz_suppress, input, 1, 1 blanks leading zero digits.
- load_valid, input, 1, new frame offered.
- load_data, input, 4*NUM_DIGITS, digit codes; digit 0 = bits [3:0] = rightmost digit.
- load_ready, output, 1, driver can accept a frame.
- seg, output, 7, segments {a,b,c,d,e,f,g}, a = bit 6.
- an, output, NUM_DIGITS, digit select, one-hot when active.
- digit_idx, output, $clog2(NUM_DIGITS), index of the digit currently driven.

Behaviour:
- Reset (rst_n low, asynchronous):
  - prescaler = 0, digit_idx = 0, display register = 0, pending = 0, load_ready = 1.
  - an = all inactive, seg = all inactive (0 if SEG_ACTIVE_LOW = 0).
  - Reset mid-frame discards any pending frame.
- Prescaler: counts 0..SCAN_DIV-1 while enable = 1.
  - At terminal count it wraps to 0 and digit_idx increments, with N-1 wrapping to 0.
  - The frame boundary is terminal count with digit_idx = N-1.
- Handshake:
  - A frame is accepted when load_valid & load_ready at a rising edge; it is stored in a shadow register, pending goes to 1 and load_ready goes to 0 on the next cycle.
  - At the next frame boundary, shadow is copied to the display register, pending goes to 0 and load_ready returns to 1 on the following cycle.
  - If enable = 0, a pending frame is copied on the cycle after acceptance; load_ready returns to 1 one cycle later.
  - A new frame cannot overwrite the shadow while pending = 1.
- Dead time:
  - When prescaler = 0, an is all inactive (anti-ghosting).
  - For prescaler 1..SCAN_DIV-1, an has exactly bit digit_idx active.
- Output registration:
  - an and seg are registered from the current (prescaler, digit_idx, display) state, giving 1 cycle latency.
  - Both change on the same edge and never disagree for a cycle.
- enable = 0: prescaler and digit_idx hold; an and seg are inactive from the next cycle. Re-enable resumes from the held state.
- Glyphs, common to both modes (active-high form, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Glyphs, HEX_MODE = 0:
  - 10 = blank, 11 = blank
  - 12 = 1100111 ("P"), 13 = 1110111 ("A")
  - 14 = blank, 15 = 0000001 ("-")
- Glyphs, HEX_MODE = 1:
  - A=1110111, b=0011111, C=1001110
  - d=0111101, E=1001111, F=1000111
- Leading-zero suppression: digit i > 0 is blanked (seg inactive, an still active) when lz_suppress = 1, code[i] = 0, and all codes above i are 0. Digit 0 is never suppressed.
- Polarity:
  - SEG_ACTIVE_LOW inverts seg after decode and blanking.
  - AN_ACTIVE_LOW inverts an after select and dead time.

Decomposition:
- Package seg7_pkg holds:
  - the glyph constants (digit glyphs, symbol glyphs P/A/dash, hex A–F, BLANK);
  - a localparam for the BCD/hex mode encoding;
  - a glyph lookup function decode(code, hex_mode).
- One combinational sub-module, seg7_glyph_rom (inputs code[3:0], hex_mode, blank; output seg[6:0]), instanced once on the selected digit.
- Scanner, handshake and polarity logic stay in seg7_scan_driver.

Test Plan:
- Test parameters for all cases: NUM_DIGITS = 4, SCAN_DIV = 4, HEX_MODE = 0, polarities default.
- Reset release, enable = 1, no load: an cycles 1111 → 1110 (×3) → 1111 → 1101 (×3)…; seg = 1111110 on active cycles; digit_idx wraps 3 → 0 every 16 cycles.
- Load 16'h12CF mid-frame: load_ready drops next cycle; display is unchanged until the frame boundary.
  - After the boundary: digit0 = 0000001, digit1 = 1100111, digit2 = 1101101, digit3 = 0110000.
  - load_ready rises 1 cycle after the boundary.
- With pending = 1, assert load_valid with 16'h9999: it is not accepted (load_ready = 0); the first frame is displayed, and 9999 is accepted only after load_ready returns to 1.
- lz_suppress = 1, load 16'h0050: digits 3 and 2 blank (seg inactive, an active); digit1 = 1011011, digit0 = 1111110. Load 16'h0000: only digit0 shows 1111110.
- HEX_MODE = 1 instance, load 16'hAbCd: digit0 = 0111101, digit1 = 1001110, digit2 = 0011111, digit3 = 1110111.
- Async reset pulse mid-scan with pending = 1: an and seg go inactive immediately (no clock edge), load_ready = 1, digit_idx = 0, and the pending frame is never displayed.
